gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Transmit-side Ethernet MAC framer. Takes one frame at a time on a byte-wide AXI-Stream input (destination MAC through end of payload) and drives it onto the GMII transmit pins `eth_txd`, `eth_txen` and `eth_txer`. On the wire each frame gets a 7-byte preamble and SFD, zero padding up to the minimum frame size, an IEEE 802.3 FCS, and an inter-frame gap. It sits between the packet generators (ARP/IP responders) and the PHY, and is the transmit counterpart of the GMII receive path.

## Interface

Parameters:
- `MIN_FRAME`, default 60: minimum bytes before the FCS; shorter payloads are zero-padded to this length.
- `IFG_BYTES`, default 12: idle cycles after the FCS before the next preamble may start.

Ports:
- `clk`  in  1: transmit byte clock (125 MHz, shared with `eth_gtxclk`).
- `aresetn`  in  1: asynchronous, active-low reset.
- `axis_i_tvalid`  in  1: input byte valid.
- `axis_i_tready`  out  1: input byte accepted this cycle.
- `axis_i_tdata`  in  8: frame byte, destination MAC first.
- `axis_i_tlast`  in  1: last payload byte of the frame.
- `eth_txd`  out  8: GMII transmit data.
- `eth_txen`  out  1: GMII transmit enable.
- `eth_txer`  out  1: GMII transmit error.

## Operation

- All outputs are registered.
- Reset values: `eth_txd`=0x00, `eth_txen`=0, `eth_txer`=0, `axis_i_tready`=0.
- Reset state: IDLE, CRC register = 0xFFFFFFFF, byte counter = 0.
- States:
  - IDLE: `axis_i_tvalid`=1 causes a transition to PRE. Nothing is consumed.
  - PRE: drives 0x55 for 7 cycles, then goes to SFD.
  - SFD: drives 0xD5. `axis_i_tready` is high during this cycle, then goes to DATA.
  - DATA:
    - Each accepted byte is driven on the next cycle and is added to the CRC and the counter.
    - When tlast is accepted, goes to PAD if counter < `MIN_FRAME`, else to FCS.
  - PAD: drives 0x00 bytes, each included in the CRC, until counter = `MIN_FRAME`, then goes to FCS.
  - FCS: drives `~crc`, least significant byte first, for 4 cycles, then goes to IFG.
  - IFG: `eth_txen`=0 for `IFG_BYTES` cycles, then goes to IDLE.
- CRC: reflected CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Updated one byte per cycle.
- Byte counter: 16-bit, saturates at 0xFFFF. There is no maximum-length check.
- `axis_i_tready` is high only while the SFD is on the wire and while in DATA before tlast is accepted.
- Underrun (`axis_i_tvalid`=0 while in DATA):
  - The next wire cycle carries `eth_txen`=1, `eth_txer`=1, `eth_txd`=0x00.
  - State moves to DRAIN, with `eth_txen`=0 and `axis_i_tready`=1. Input bytes are discarded through tlast, then the block goes to IFG.
  - No FCS is sent for the aborted frame.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronous) and the frame is truncated. After reset releases, the next input frame starts cleanly from IDLE.

## Timing

- Start latency: `axis_i_tvalid` first sampled high in IDLE at edge N gives 0x55 with `eth_txen`=1 after edge N+1.
  - Preamble occupies edges N+1..N+7 and the SFD edge N+8.
  - The first data byte is accepted at edge N+8 and is on the wire after edge N+9.
- Per-byte latency: a byte accepted at edge k is on `eth_txd` after edge k+1.
- A source that keeps tvalid high produces back-to-back data with no bubbles.
- `eth_txen` length for a P-byte payload: 8 + max(P, `MIN_FRAME`) + 4 contiguous cycles.
- Minimum spacing between frames: `IFG_BYTES` cycles with `eth_txen`=0. A new frame held pending during IFG starts 1 cycle after IFG ends (one IDLE cycle).

## Test plan

- 42-byte ARP reply (broadcast destination, source 22:AC:10:F7:89:BB, EtherType 0806) -> preamble 55×7 then D5, 42 bytes, 18×0x00 pad, then 4 FCS bytes. `eth_txen` high for exactly 72 cycles. FCS matches a software CRC-32 of the 60 bytes.
- `MIN_FRAME`=0, payload ASCII "123456789" -> FCS on the wire is 26 39 F4 CB.
- 64-byte payload with tvalid held high -> no padding, `eth_txen` high for 76 cycles, `axis_i_tready` high for exactly 64 cycles.
- Two frames presented back to back -> `eth_txen` low for exactly 13 cycles between them (12 IFG + 1 IDLE), and the second frame's CRC is independent of the first.
- Underrun: tvalid dropped after byte 10 of 20 -> one wire cycle with `eth_txer`=1; remaining bytes are consumed with `eth_txen`=0 and no FCS is sent; the next frame is transmitted correctly.
- `aresetn` pulsed low during DATA -> `eth_txen`, `eth_txer`, `eth_txd` and `axis_i_tready` go to 0 without a clock edge; a fresh frame after release is bit-exact.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: byte-wide AXI-Stream to GMII transmit framer.
// Wraps each frame in preamble/SFD, zero-pads to MIN_FRAME, appends the
// reflected CRC-32 FCS and enforces the inter-frame gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | wire quiet, waiting for tvalid; CRC and byte count re-armed
// PRE     | driving 0x55, seven cycles timed by tmr_q
// SFD     | driving 0xD5, first payload byte may be accepted
// DATA    | driving the byte accepted last cycle, accepting the next
// LAST    | driving the byte accepted with tlast
// PAD     | driving 0x00 until the byte count reaches MIN_FRAME
// FCS     | driving ~crc, least significant byte first, four cycles
// ABORT   | underrun marker cycle: txen=1, txer=1, txd=0x00
// DRAIN   | wire quiet, discarding input through tlast
// IFG     | wire quiet for IFG_BYTES cycles
module gmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       axis_i_tvalid,
    output logic       axis_i_tready,
    input  logic [7:0] axis_i_tdata,
    input  logic       axis_i_tlast,
    output logic [7:0] eth_txd,
    output logic       eth_txen,
    output logic       eth_txer
);

    localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LOAD = (IFG_BYTES > 0) ? 16'(IFG_BYTES - 1) : 16'd0;
    localparam logic [15:0] PRE_LOAD = 16'd6;
    localparam logic [15:0] FCS_LOAD = 16'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_LAST,
        S_PAD,
        S_FCS,
        S_ABORT,
        S_DRAIN,
        S_IFG
    } state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic [15:0] tmr_q;
    logic [7:0]  hold_q;
    logic [7:0]  txd_q;
    logic        txen_q;
    logic        txer_q;
    logic        tready_q;

    logic [31:0] crc_hold_d;
    logic [31:0] crc_zero_d;
    logic [15:0] cnt_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Candidate CRC updates for the byte going out and the saturating count step.
    always_comb begin
        crc_hold_d = crc_byte(crc_q, hold_q);
        crc_zero_d = crc_byte(crc_q, 8'h00);
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Framer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            crc_q    <= 32'hFFFF_FFFF;
            cnt_q    <= 16'd0;
            tmr_q    <= 16'd0;
            hold_q   <= 8'h00;
            txd_q    <= 8'h00;
            txen_q   <= 1'b0;
            txer_q   <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            txer_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd_q    <= 8'h00;
                    txen_q   <= 1'b0;
                    tready_q <= 1'b0;
                    crc_q    <= 32'hFFFF_FFFF;
                    cnt_q    <= 16'd0;
                    if (axis_i_tvalid) begin
                        state_q <= S_PRE;
                        tmr_q   <= PRE_LOAD;
                    end
                end
                S_PRE: begin
                    txd_q  <= 8'h55;
                    txen_q <= 1'b1;
                    if (tmr_q == 16'd0) begin
                        state_q  <= S_SFD;
                        tready_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                S_SFD: begin
                    txd_q  <= 8'hD5;
                    txen_q <= 1'b1;
                    if (axis_i_tvalid) begin
                        hold_q <= axis_i_tdata;
                        cnt_q  <= cnt_d;
                        if (axis_i_tlast) begin
                            tready_q <= 1'b0;
                            state_q  <= S_LAST;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        state_q <= S_ABORT;
                    end
                end
                S_DATA: begin
                    txd_q  <= hold_q;
                    txen_q <= 1'b1;
                    crc_q  <= crc_hold_d;
                    if (axis_i_tvalid) begin
                        hold_q <= axis_i_tdata;
                        cnt_q  <= cnt_d;
                        if (axis_i_tlast) begin
                            tready_q <= 1'b0;
                            state_q  <= S_LAST;
                        end
                    end else begin
                        // Source ran dry: the byte already held still goes out first.
                        state_q <= S_ABORT;
                    end
                end
                S_LAST: begin
                    txd_q  <= hold_q;
                    txen_q <= 1'b1;
                    crc_q  <= crc_hold_d;
                    if (cnt_q < MIN_W) begin
                        state_q <= S_PAD;
                    end else begin
                        state_q <= S_FCS;
                        tmr_q   <= FCS_LOAD;
                    end
                end
                S_PAD: begin
                    txd_q  <= 8'h00;
                    txen_q <= 1'b1;
                    crc_q  <= crc_zero_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d >= MIN_W) begin
                        state_q <= S_FCS;
                        tmr_q   <= FCS_LOAD;
                    end
                end
                S_FCS: begin
                    txd_q  <= ~crc_q[7:0];
                    txen_q <= 1'b1;
                    crc_q  <= {8'h00, crc_q[31:8]};
                    if (tmr_q == 16'd0) begin
                        state_q <= S_IFG;
                        tmr_q   <= IFG_LOAD;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                S_ABORT: begin
                    txd_q  <= 8'h00;
                    txen_q <= 1'b1;
                    txer_q <= 1'b1;
                    if (axis_i_tvalid && axis_i_tlast) begin
                        tready_q <= 1'b0;
                        state_q  <= S_IFG;
                        tmr_q    <= IFG_LOAD;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    txd_q  <= 8'h00;
                    txen_q <= 1'b0;
                    if (axis_i_tvalid && axis_i_tlast) begin
                        tready_q <= 1'b0;
                        state_q  <= S_IFG;
                        tmr_q    <= IFG_LOAD;
                    end
                end
                S_IFG: begin
                    txd_q    <= 8'h00;
                    txen_q   <= 1'b0;
                    tready_q <= 1'b0;
                    if (tmr_q == 16'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    txd_q    <= 8'h00;
                    txen_q   <= 1'b0;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

    assign axis_i_tready = tready_q;
    assign eth_txd       = txd_q;
    assign eth_txen      = txen_q;
    assign eth_txer      = txer_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: expected wire bytes are queued as stimulus is
// accepted and compared as the DUT puts them on GMII.
module tb_gmii_tx_framer;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       tv = 1'b0;
    logic       tl = 1'b0;
    logic [7:0] td = 8'h00;
    bit         sel_m0 = 1'b0;

    logic       tv_a, tl_a, rdy_a, txen_a, txer_a;
    logic [7:0] txd_a;
    logic       tv_b, tl_b, rdy_b, txen_b, txer_b;
    logic [7:0] txd_b;
    logic       cur_tready, cur_txen, cur_txer;
    logic [7:0] cur_txd;

    logic [8:0]  exp_q[$];
    bq_t         frm;
    int          checks = 0;
    int          fails = 0;
    int          txen_cnt = 0;
    int          txer_cnt = 0;
    int          rdy_cnt = 0;
    int          low_run = 0;
    int          last_gap = 0;
    logic [31:0] last4 = 32'h0;

    localparam logic [335:0] ARP = 336'hFFFFFFFFFFFF_22AC10F789BB_0806_0001_0800_06_04_0002_22AC10F789BB_C0A80164_0A1B2C3D4E5F_C0A80102;

    always #4 clk = ~clk;

    assign tv_a = tv & ~sel_m0;
    assign tl_a = tl & ~sel_m0;
    assign tv_b = tv & sel_m0;
    assign tl_b = tl & sel_m0;
    assign cur_tready = sel_m0 ? rdy_b  : rdy_a;
    assign cur_txen   = sel_m0 ? txen_b : txen_a;
    assign cur_txer   = sel_m0 ? txer_b : txer_a;
    assign cur_txd    = sel_m0 ? txd_b  : txd_a;

    gmii_tx_framer u_dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .axis_i_tvalid (tv_a),
        .axis_i_tready (rdy_a),
        .axis_i_tdata  (td),
        .axis_i_tlast  (tl_a),
        .eth_txd       (txd_a),
        .eth_txen      (txen_a),
        .eth_txer      (txer_a)
    );

    gmii_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) u_dut_m0 (
        .clk           (clk),
        .aresetn       (aresetn),
        .axis_i_tvalid (tv_b),
        .axis_i_tready (rdy_b),
        .axis_i_tdata  (td),
        .axis_i_tlast  (tl_b),
        .eth_txd       (txd_b),
        .eth_txen      (txen_b),
        .eth_txer      (txer_b)
    );

    // CRC-32 computed MSB-first on the non-reflected polynomial, bits fed LSB first.
    function automatic logic [31:0] crc_model(input bq_t q);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ q[k][i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        logic [8:0] e;
        if (cur_txen === 1'b1) begin
            txen_cnt++;
            if (cur_txer === 1'b1) txer_cnt++;
            last4 = {last4[23:0], cur_txd};
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wire_byte", {23'd0, cur_txer, cur_txd}, {23'd0, e});
            end else begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL wire_extra got txd=%0h txer=%0b exp=none", cur_txd, cur_txer);
                end
            end
        end else begin
            low_run++;
        end
        if (cur_tready === 1'b1) rdy_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic clr_stats();
        txen_cnt = 0;
        txer_cnt = 0;
        rdy_cnt  = 0;
        last4    = 32'h0;
    endtask

    task automatic fill_rand(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input int len, input int stall_at, input int rst_at);
        bq_t         sent;
        bit          aborted;
        bit          acc;
        int          idx;
        int          budget;
        int          minf;
        logic [31:0] fcs;
        aborted = 1'b0;
        idx     = 0;
        budget  = 0;
        minf    = sel_m0 ? 0 : 60;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        tv = 1'b1;
        td = frm[0];
        tl = (len == 1);
        while (idx < len && budget < 4000) begin
            acc = tv && (cur_tready === 1'b1);
            tick();
            budget++;
            if (acc) begin
                if (!aborted) begin
                    exp_q.push_back({1'b0, frm[idx]});
                    sent.push_back(frm[idx]);
                end
                idx++;
                if (idx < len) begin
                    td = frm[idx];
                    tl = (idx == len - 1);
                end else begin
                    tv = 1'b0;
                    tl = 1'b0;
                    td = 8'h00;
                end
                if (!aborted && idx == stall_at && idx < len) begin
                    tv      = 1'b0;
                    aborted = 1'b1;
                    exp_q.push_back({1'b1, 8'h00});
                end
                if (idx == rst_at) begin
                    chk("pre_rst_txen", {31'd0, cur_txen}, 32'd1);
                    #2 aresetn = 1'b0;
                    #1;
                    chk("rst_txen", {31'd0, cur_txen}, 32'd0);
                    chk("rst_txer", {31'd0, cur_txer}, 32'd0);
                    chk("rst_txd", {24'd0, cur_txd}, 32'd0);
                    chk("rst_tready", {31'd0, cur_tready}, 32'd0);
                    tv = 1'b0;
                    tl = 1'b0;
                    exp_q.delete();
                    tick();
                    tick();
                    aresetn = 1'b1;
                    return;
                end
            end else if (aborted && !tv && idx < len) begin
                tv = 1'b1;
            end
        end
        chk("send_budget", idx, len);
        if (!aborted) begin
            while (sent.size() < minf) begin
                sent.push_back(8'h00);
                exp_q.push_back(9'h000);
            end
            fcs = crc_model(sent);
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, fcs[8*i +: 8]});
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while ((exp_q.size() > 0 || cur_txen === 1'b1) && budget < 2000) begin
            tick();
            budget++;
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (16) tick();
    endtask

    initial begin
        logic [335:0] arp_v;
        string        s;

        repeat (3) tick();
        chk("reset_txd", {24'd0, txd_a}, 32'd0);
        chk("reset_txen", {31'd0, txen_a}, 32'd0);
        chk("reset_txer", {31'd0, txer_a}, 32'd0);
        chk("reset_tready", {31'd0, rdy_a}, 32'd0);
        aresetn = 1'b1;
        repeat (4) tick();
        chk("idle_tready", {31'd0, rdy_a}, 32'd0);
        chk("idle_txen", {31'd0, txen_a}, 32'd0);

        // ARP reply, padded to 60 bytes.
        arp_v = ARP;
        frm.delete();
        for (int i = 0; i < 42; i++) frm.push_back(arp_v[335 - 8*i -: 8]);
        clr_stats();
        send_frame(42, -1, -1);
        wait_done();
        chk("arp_txen_len", txen_cnt, 72);
        chk("arp_tready_len", rdy_cnt, 42);

        // Check value on the no-padding instance.
        sel_m0 = 1'b1;
        s = "123456789";
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(s[i]);
        clr_stats();
        send_frame(9, -1, -1);
        wait_done();
        chk("chk_txen_len", txen_cnt, 21);
        chk("chk_fcs_wire", last4, 32'h2639_F4CB);
        sel_m0 = 1'b0;

        // Full-length frame, no padding.
        fill_rand(64);
        clr_stats();
        send_frame(64, -1, -1);
        wait_done();
        chk("f64_txen_len", txen_cnt, 76);
        chk("f64_tready_len", rdy_cnt, 64);

        // Back-to-back frames.
        clr_stats();
        fill_rand(50);
        send_frame(50, -1, -1);
        fill_rand(70);
        send_frame(70, -1, -1);
        wait_done();
        chk("b2b_gap", last_gap, 13);
        chk("b2b_txen_len", txen_cnt, 154);

        // Underrun after 10 of 20 bytes, then a clean frame.
        fill_rand(20);
        clr_stats();
        send_frame(20, 10, -1);
        wait_done();
        chk("urun_txen_len", txen_cnt, 19);
        chk("urun_txer_cnt", txer_cnt, 1);
        fill_rand(30);
        clr_stats();
        send_frame(30, -1, -1);
        wait_done();
        chk("post_urun_txen_len", txen_cnt, 72);
        chk("post_urun_txer_cnt", txer_cnt, 0);

        // Reset mid-DATA, then a fresh frame.
        fill_rand(40);
        send_frame(40, -1, 20);
        repeat (3) tick();
        chk("post_rst_txen", {31'd0, txen_a}, 32'd0);
        fill_rand(45);
        clr_stats();
        send_frame(45, -1, -1);
        wait_done();
        chk("post_rst_txen_len", txen_cnt, 72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
